// File: rtl/line_burst_pkg.sv
// Shared types and defaults for the line burst master.
package line_burst_pkg;

    localparam int LINE_W_DEF  = 256;
    localparam int BURST_W_DEF = 64;
    localparam int TIMEOUT_DEF = 10000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [31:0] line_align(input logic [31:0] addr, input int off_bits);
        logic [31:0] mask;
        mask = ~((32'd1 << off_bits) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/burst_timeout_ctr.sv
// Saturating watchdog counter; expired_o flags the final waiting cycle so the
// abort lands exactly TIMEOUT_CYCLES cycles after the last clear.
module burst_timeout_ctr
    import line_burst_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear dominates, otherwise count up while enabled and not saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/line_burst_master.sv
// Splits cache line reads/writes into BURSTS memory beats with a response
// watchdog; every output is driven straight from a register.
module line_burst_master
    import line_burst_pkg::*;
#(
    parameter int LINE_W         = LINE_W_DEF,
    parameter int BURST_W        = BURST_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic               err_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);

    localparam int BURSTS   = LINE_W / BURST_W;
    localparam int BEAT_W   = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int OFF_BITS = $clog2(LINE_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURSTS - 1);

    state_e              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [BEAT_W-1:0]   beat_nxt_s;
    logic [LINE_W-1:0]   buf_q;
    logic [LINE_W-1:0]   line_q;
    logic [31:0]         addr_q;
    logic [BURST_W-1:0]  burst_q;
    logic                read_q;
    logic                write_q;
    logic                resp_q;
    logic                err_q;
    logic                tmo_clear_s;
    logic                tmo_enable_s;
    logic                tmo_expired_s;

    // Wraps to 0 after the last beat, so the write slice index never leaves the line.
    assign beat_nxt_s   = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
    assign tmo_enable_s = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign tmo_clear_s  = (state_q == ST_IDLE) || (tmo_enable_s && resp_i);

    burst_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmo_clear_s),
        .enable_i  (tmo_enable_s),
        .expired_o (tmo_expired_s)
    );

    // Control FSM together with all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            buf_q   <= '0;
            line_q  <= '0;
            addr_q  <= 32'd0;
            burst_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    beat_q <= '0;
                    if (write_i || read_i) begin
                        addr_q  <= line_align(address_i, OFF_BITS);
                        buf_q   <= line_i;
                        burst_q <= line_i[BURST_W-1:0];
                        write_q <= write_i;
                        read_q  <= !write_i;
                        state_q <= write_i ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (resp_i) begin
                        line_q[int'(beat_q)*BURST_W +: BURST_W] <= burst_i;
                        beat_q <= beat_nxt_s;
                        if (beat_q == LAST_BEAT) begin
                            read_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end else if (tmo_expired_s) begin
                        read_q  <= 1'b0;
                        err_q   <= 1'b1;
                        beat_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (resp_i) begin
                        burst_q <= buf_q[int'(beat_nxt_s)*BURST_W +: BURST_W];
                        beat_q  <= beat_nxt_s;
                        if (beat_q == LAST_BEAT) begin
                            write_q <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end else if (tmo_expired_s) begin
                        write_q <= 1'b0;
                        err_q   <= 1'b1;
                        beat_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    resp_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    beat_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign line_o    = line_q;
    assign resp_o    = resp_q;
    assign err_o     = err_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign burst_o   = burst_q;

endmodule
